// File: rtl/paint_pkg.sv
// Shared definitions for the direction-key front end: bit positions of each
// direction, FSM state encoding and the opposing-key cancellation rule.
package paint_pkg;

    localparam int NUM_DIRS  = 4;
    localparam int DIR_LEFT  = 3;
    localparam int DIR_UP    = 2;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } fsm_state_e;

    // Opposing keys on the same axis cancel each other; the other axis is untouched.
    function automatic logic [NUM_DIRS-1:0] cancel_opposing(input logic [NUM_DIRS-1:0] deb);
        logic [NUM_DIRS-1:0] m;
        m = deb;
        if (deb[DIR_LEFT] && deb[DIR_RIGHT]) begin
            m[DIR_LEFT]  = 1'b0;
            m[DIR_RIGHT] = 1'b0;
        end
        if (deb[DIR_UP] && deb[DIR_DOWN]) begin
            m[DIR_UP]   = 1'b0;
            m[DIR_DOWN] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchroniser followed by a counter that only lets a level
// through after it has differed from the debounced value for DEBOUNCE_CYCLES edges.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 24
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_deb
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            // The edge that completes the run flips the output and restarts the count.
            if (cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_deb = deb_q;

endmodule

// File: rtl/direction_repeat_ctrl.sv
// Turns four raw direction keys into single-cycle step pulses with an initial
// delay and a fixed auto-repeat rate while the same key set stays held.
module direction_repeat_ctrl
    import paint_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int INITIAL_DELAY   = 5000000,
    parameter int REPEAT_PERIOD   = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_DIRS-1:0] keys,
    output logic [NUM_DIRS-1:0] directions,
    output logic                active
);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INITIAL_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_DIRS-1:0] deb;
    logic [NUM_DIRS-1:0] mask;

    generate
        for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_deb (
                .clock   (clock),
                .reset   (reset),
                .key_raw (keys[gi]),
                .key_deb (deb[gi])
            );
        end
    endgenerate

    always_comb begin
        mask = cancel_opposing(deb);
    end

    fsm_state_e          state_q, state_d;
    logic [NUM_DIRS-1:0] held_q, held_d;
    logic                repeating_q, repeating_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_DIRS-1:0] dir_q, dir_d;
    logic                active_q, active_d;
    logic [CNT_W-1:0]    wait_last;

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        repeating_d = repeating_q;
        cnt_d       = cnt_q;
        dir_d       = '0;
        wait_last   = repeating_q ? REP_LAST : INIT_LAST;

        unique case (state_q)
            ST_IDLE: begin
                if (mask != '0) begin
                    state_d     = ST_FIRE;
                    held_d      = mask;
                    repeating_d = 1'b0;
                    dir_d       = mask;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (mask == '0) begin
                    state_d = ST_IDLE;
                end else if (mask != held_q) begin
                    // A different key set restarts the hold and fires straight away.
                    state_d     = ST_FIRE;
                    held_d      = mask;
                    repeating_d = 1'b0;
                    dir_d       = mask;
                end else if (cnt_q == wait_last) begin
                    state_d     = ST_FIRE;
                    repeating_d = 1'b1;
                    dir_d       = held_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d != ST_IDLE);
    end

    // Pulse and activity outputs come straight from flops so the downstream stage sees no glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            repeating_q <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            repeating_q <= repeating_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            active_q    <= active_d;
        end
    end

    assign directions = dir_q;
    assign active     = active_q;

endmodule

// File: tb/tb_direction_repeat_ctrl.sv
// Directed and random stimulus for direction_repeat_ctrl, checked every cycle
// against a timeline model of hold/fire behaviour plus literal pulse timings.
module tb_direction_repeat_ctrl;

    localparam int DEB  = 4;
    localparam int INIT = 10;
    localparam int REP  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys  = 4'b0000;
    logic [3:0] directions;
    logic       active;

    direction_repeat_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .INITIAL_DELAY   (INIT),
        .REPEAT_PERIOD   (REP),
        .CNT_W           (24)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .keys       (keys),
        .directions (directions),
        .active     (active)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [3:0] legal_mask(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[3] && d[1]) r = r & 4'b0101;
        if (d[2] && d[0]) r = r & 4'b1010;
        return r;
    endfunction

    // Model: debounced levels, then a schedule of when the next pulse is due.
    logic [3:0] s1_m, s2_m, deb_m, held_m, exp_dir;
    logic       idle_m, fired_m, exp_act;
    int         run_m [4];
    int         due_m, k_m;

    always @(posedge clock or posedge reset) begin : model
        logic [3:0] m;
        int         kk;
        if (reset) begin
            s1_m    <= '0;
            s2_m    <= '0;
            deb_m   <= '0;
            held_m  <= '0;
            exp_dir <= '0;
            exp_act <= 1'b0;
            idle_m  <= 1'b1;
            fired_m <= 1'b0;
            due_m   <= 0;
            k_m     <= 0;
            for (int b = 0; b < 4; b++) run_m[b] <= 0;
        end else begin
            m  = legal_mask(deb_m);
            kk = k_m + 1;
            k_m     <= kk;
            exp_dir <= '0;
            fired_m <= 1'b0;
            if (fired_m) begin
                // the cycle after a pulse is always a quiet wait cycle
            end else if (idle_m) begin
                if (m != 0) begin
                    exp_dir <= m; held_m <= m; due_m <= kk + INIT + 1;
                    idle_m <= 1'b0; exp_act <= 1'b1; fired_m <= 1'b1;
                end
            end else if (m == 0) begin
                idle_m <= 1'b1; exp_act <= 1'b0;
            end else if (m != held_m) begin
                exp_dir <= m; held_m <= m; due_m <= kk + INIT + 1; fired_m <= 1'b1;
            end else if (kk == due_m) begin
                exp_dir <= held_m; due_m <= kk + REP + 1; fired_m <= 1'b1;
            end
            for (int b = 0; b < 4; b++) begin
                if (s2_m[b] != deb_m[b]) begin
                    if (run_m[b] + 1 >= DEB) begin
                        deb_m[b] <= s2_m[b];
                        run_m[b] <= 0;
                    end else begin
                        run_m[b] <= run_m[b] + 1;
                    end
                end else begin
                    run_m[b] <= 0;
                end
            end
            s2_m <= s1_m;
            s1_m <= keys;
        end
    end

    int         total = 0;
    int         bad   = 0;
    int         pulse_t[$];
    logic [3:0] pulse_v[$];
    logic       prev_nz  = 1'b0;
    logic       act_seen = 1'b0;

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_pulse(input string name, input int idx, input int t, input logic [3:0] v);
        total++;
        if (idx >= pulse_t.size()) begin
            bad++;
            $display("FAIL %s: pulse #%0d missing, expected %b at cycle %0d", name, idx, v, t);
        end else if (pulse_t[idx] != t || pulse_v[idx] !== v) begin
            bad++;
            $display("FAIL %s: got %b at cycle %0d expected %b at cycle %0d",
                     name, pulse_v[idx], pulse_t[idx], v, t);
        end
    endtask

    task automatic cycle_check();
        if (!reset) begin
            chk4("dir_vs_model", directions, exp_dir);
            chk4("active_vs_model", {3'b000, active}, {3'b000, exp_act});
            chk4("dir_not_consecutive", {3'b000, prev_nz && (directions != 0)}, 4'b0000);
            chk4("dir_no_opposing", {2'b00, directions[3] & directions[1], directions[2] & directions[0]}, 4'b0000);
            if (directions != 0) begin
                pulse_t.push_back(cyc);
                pulse_v.push_back(directions);
                $display("pulse %b at cycle %0d", directions, cyc);
            end
            if (active) act_seen = 1'b1;
            prev_nz = (directions != 0);
        end else begin
            prev_nz = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            cycle_check();
        end
    endtask

    initial begin
        int t0, t1, base, late;
        step(3);
        chk4("reset_dir", directions, 4'b0000);
        chk4("reset_active", {3'b000, active}, 4'b0000);
        reset = 1'b0;
        step(5);

        // 1: single key held, then released
        base = pulse_t.size(); t0 = cyc; keys = 4'b0010;
        step(30);
        chk_pulse("t1_first", base, t0 + 7, 4'b0010);
        chk_pulse("t1_second", base + 1, t0 + 18, 4'b0010);
        chk_pulse("t1_third", base + 2, t0 + 22, 4'b0010);
        chk_pulse("t1_fourth", base + 3, t0 + 26, 4'b0010);
        t1 = cyc; keys = 4'b0000;
        step(20);
        late = 0;
        for (int i = base; i < pulse_t.size(); i++) if (pulse_t[i] > t1 + 7) late++;
        chk_int("t1_no_trailing", late, 0);
        chk4("t1_idle_after_release", {3'b000, active}, 4'b0000);

        // 2: short glitch never gets through
        base = pulse_t.size(); act_seen = 1'b0; keys = 4'b1000;
        step(3);
        keys = 4'b0000;
        step(20);
        chk_int("t2_no_pulse", pulse_t.size() - base, 0);
        chk4("t2_never_active", {3'b000, act_seen}, 4'b0000);

        // 3: left+right cancel, adding up fires up only
        base = pulse_t.size(); keys = 4'b1010;
        step(15);
        chk_int("t3_cancelled", pulse_t.size() - base, 0);
        t0 = cyc; keys = 4'b1110;
        step(12);
        chk_pulse("t3_up_only", base, t0 + 7, 4'b0100);
        keys = 4'b0000;
        step(20);

        // 4: changing the held set restarts the initial delay
        base = pulse_t.size(); t0 = cyc; keys = 4'b0001;
        step(23);
        t1 = cyc; keys = 4'b1001;
        step(30);
        chk_pulse("t4_first", base, t0 + 7, 4'b0001);
        chk_pulse("t4_rep1", base + 1, t0 + 18, 4'b0001);
        chk_pulse("t4_rep2", base + 2, t0 + 22, 4'b0001);
        chk_pulse("t4_rep3", base + 3, t0 + 26, 4'b0001);
        chk_pulse("t4_newset", base + 4, t1 + 7, 4'b1001);
        chk_pulse("t4_new_gap11", base + 5, t1 + 18, 4'b1001);
        chk_pulse("t4_new_gap4", base + 6, t1 + 22, 4'b1001);
        keys = 4'b0000;
        step(20);

        // 5: asynchronous reset while repeating, key kept held
        t0 = cyc; keys = 4'b0010;
        step(24);
        chk4("t5_active_before_reset", {3'b000, active}, 4'b0001);
        #2 reset = 1'b1;
        #1;
        chk4("t5_async_dir", directions, 4'b0000);
        chk4("t5_async_active", {3'b000, active}, 4'b0000);
        step(3);
        reset = 1'b0; base = pulse_t.size(); t0 = cyc;
        step(25);
        chk_pulse("t5_replay_first", base, t0 + 7, 4'b0010);
        chk_pulse("t5_replay_second", base + 1, t0 + 18, 4'b0010);
        keys = 4'b0000;
        step(20);

        // 6: random key activity checked against the model every cycle
        t0 = cyc;
        while (cyc - t0 < 10000) begin
            keys = 4'($urandom_range(0, 15));
            step(int'($urandom_range(1, 12)));
        end
        keys = 4'b0000;
        step(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
